// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the spi_arbiter block: state encoding, the layout of
// a requester's 6-bit mode word, the default transfer length and the lock limit.
package spi_arbiter_pkg;

    // State encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;
    localparam logic [2:0] ST_ABORT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_WAIT  = ST_WAIT,
        S_READ  = ST_READ,
        S_ACK   = ST_ACK,
        S_ABORT = ST_ABORT
    } state_t;

    // Per-requester mode word: {cpol, cpha, xfer_len[3:0]}
    localparam int CFG_W        = 6;
    localparam int CFG_LEN_LSB  = 0;
    localparam int CFG_LEN_W    = 4;
    localparam int CFG_CPHA_BIT = 4;
    localparam int CFG_CPOL_BIT = 5;

    // Length used when a requester asks for 0 or more than a full word
    localparam logic [CFG_LEN_W-1:0] LEN_DEFAULT = 4'd8;

    // Maximum number of consecutive transfers one lock may hold the port
    localparam int LOCK_MAX   = 4;
    localparam int LOCK_CNT_W = 3;

endpackage

// File: rtl/spi_arbiter_rr.sv
// Combinational round-robin picker: the first requester with req high,
// searching from pointer upward and wrapping at N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  pointer,
    output logic [N_REQ-1:0] winner,
    output logic [ID_W-1:0]  index,
    output logic             found
);

    logic [ID_W-1:0] cand;

    // Walk the requesters in priority order starting at the pointer
    always_comb begin
        winner = '0;
        index  = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(pointer) + k) % N_REQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                index        = cand;
                winner[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one flex_spi master between N_REQ requesters with
// round-robin arbitration. Each grant runs one word transfer
// (LOAD -> WAIT for done -> READ -> ACK) using the winner's own cpol/cpha/len.
// A requester holding req_lock may chain up to LOCK_MAX transfers without
// returning to arbitration.
// Optional build macro SPI_ARBITER_TIMEOUT_EN adds a WAIT watchdog that aborts
// the flex_spi transfer after TIMEOUT_CYCLES and acks with rx_err=1, rx_data=0.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int ID_W           = 2,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_lock,
    input  logic [N_REQ*DATA_W-1:0] req_tx,
    input  logic [N_REQ*6-1:0]      req_cfg,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       rx_data,
    output logic                    rx_valid,
    output logic [ID_W-1:0]         rx_id,
    output logic                    rx_err,
    output logic                    spi_en,
    output logic                    spi_we,
    output logic                    spi_oe,
    output logic                    spi_cpol,
    output logic                    spi_cpha,
    output logic [3:0]              spi_xfer_len,
    output logic [DATA_W-1:0]       spi_tx,
    output logic                    spi_tx_oe,
    input  logic [DATA_W-1:0]       spi_rx,
    input  logic                    spi_busy,
    input  logic                    spi_done
);

    state_t state, state_nxt;

    logic [N_REQ-1:0]        win_onehot;
    logic [ID_W-1:0]         win_idx;
    logic                    win_found;

    logic [ID_W-1:0]         id_q;
    logic [ID_W-1:0]         ptr_q;
    logic [ID_W-1:0]         ptr_next;
    logic [ID_W-1:0]         sel_idx;
    logic [DATA_W-1:0]       tx_q;
    logic [CFG_W-1:0]        cfg_q;
    logic [N_REQ-1:0]        gnt_q;
    logic [LOCK_CNT_W-1:0]   lock_cnt;
    logic [DATA_W-1:0]       rx_q;

    logic                    grant_new;
    logic                    relock;
    logic                    latch_en;
    logic                    timeout;

    logic [DATA_W-1:0]       tx_arr  [N_REQ];
    logic [CFG_W-1:0]        cfg_arr [N_REQ];

    // flex_spi busy carries no information the done handshake does not
    logic                    busy_unused;
    assign busy_unused = spi_busy;

    // Force an out-of-range transfer length to a full word
    function automatic logic [CFG_W-1:0] fix_cfg(input logic [CFG_W-1:0] c);
        logic [CFG_LEN_W-1:0] len;
        logic [CFG_W-1:0]     res;
        len = c[CFG_LEN_LSB +: CFG_LEN_W];
        if (len == '0 || len > LEN_DEFAULT) begin
            len = LEN_DEFAULT;
        end
        res = c;
        res[CFG_LEN_LSB +: CFG_LEN_W] = len;
        return res;
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign tx_arr[i]  = req_tx[i*DATA_W +: DATA_W];
        assign cfg_arr[i] = req_cfg[i*CFG_W +: CFG_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req     (req),
        .pointer (ptr_q),
        .winner  (win_onehot),
        .index   (win_idx),
        .found   (win_found)
    );

    // A fresh grant only happens from IDLE; a locked re-grant keeps the owner
    assign grant_new = (state == S_IDLE) && win_found;
    assign latch_en  = grant_new || relock;
    assign sel_idx   = (state == S_IDLE) ? win_idx : id_q;
    assign ptr_next  = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

`ifdef SPI_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // Count cycles spent waiting for flex_spi; restarts on every WAIT entry
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (state == S_WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Remember whether the current transfer ended in an abort
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == S_ABORT) begin
            err_q <= 1'b1;
        end else if (state == S_LOAD) begin
            err_q <= 1'b0;
        end
    end

    assign rx_err = (state == S_ACK) && err_q;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
    assign rx_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and flex_spi strobe decode
    always_comb begin
        state_nxt = state;
        relock    = 1'b0;
        spi_en    = 1'b0;
        spi_we    = 1'b0;
        spi_oe    = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                spi_en    = 1'b1;
                spi_we    = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                spi_en = 1'b1;
                if (spi_done) begin
                    state_nxt = S_READ;
                end else if (timeout) begin
                    state_nxt = S_ABORT;
                end
            end
            S_READ: begin
                spi_en    = 1'b1;
                spi_oe    = 1'b1;
                state_nxt = S_ACK;
            end
            S_ABORT: begin
                // spi_en low for this one cycle tells flex_spi to abandon the word
                state_nxt = S_ACK;
            end
            S_ACK: begin
                spi_en    = 1'b1;
                relock    = req_lock[id_q] && req[id_q] &&
                            (lock_cnt < LOCK_CNT_W'(LOCK_MAX));
                state_nxt = relock ? S_LOAD : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer context: owner, latched slices, grant, lock run and pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q     <= '0;
            ptr_q    <= '0;
            tx_q     <= '0;
            cfg_q    <= '0;
            gnt_q    <= '0;
            lock_cnt <= '0;
        end else begin
            if (latch_en) begin
                id_q  <= sel_idx;
                tx_q  <= tx_arr[sel_idx];
                cfg_q <= fix_cfg(cfg_arr[sel_idx]);
            end
            if (grant_new) begin
                gnt_q    <= win_onehot;
                lock_cnt <= LOCK_CNT_W'(1);
            end else if (relock) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
            if (state == S_ACK) begin
                ptr_q <= ptr_next;
                if (!relock) begin
                    gnt_q <= '0;
                end
            end
        end
    end

    // Received word: captured from flex_spi in READ, zeroed on abort
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q <= '0;
        end else if (state == S_READ) begin
            rx_q <= spi_rx;
        end else if (state == S_ABORT) begin
            rx_q <= '0;
        end
    end

    assign gnt          = gnt_q;
    assign ack          = (state == S_ACK) ? gnt_q : '0;
    assign rx_valid     = (state == S_ACK);
    assign rx_id        = (state == S_ACK) ? id_q : '0;
    assign rx_data      = rx_q;

    // Mode pins follow the owner for the whole grant and rest at 0 in IDLE
    assign spi_cpol     = (state != S_IDLE) && cfg_q[CFG_CPOL_BIT];
    assign spi_cpha     = (state != S_IDLE) && cfg_q[CFG_CPHA_BIT];
    assign spi_xfer_len = (state != S_IDLE) ? cfg_q[CFG_LEN_LSB +: CFG_LEN_W] : '0;
    assign spi_tx       = spi_we ? tx_q : '0;
    assign spi_tx_oe    = spi_we;

endmodule

// File: tb/tb_spi_arbiter.sv
// Testbench for spi_arbiter: directed vector table, hand-written corner
// sequences (contention, lock fairness, reset mid-transfer, optional timeout)
// and randomized batches checked against a grant-order reference model.
module tb_spi_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 40;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_lock;
    logic [N*DW-1:0] req_tx;
    logic [N*6-1:0]  req_cfg;
    logic [N-1:0]    gnt, ack;
    logic [DW-1:0]   rx_data;
    logic            rx_valid;
    logic [1:0]      rx_id;
    logic            rx_err;
    logic            spi_en, spi_we, spi_oe, spi_cpol, spi_cpha;
    logic [3:0]      spi_xfer_len;
    logic [DW-1:0]   spi_tx;
    logic            spi_tx_oe;
    logic [DW-1:0]   spi_rx;
    logic            spi_busy, spi_done;

    int n_pass  = 0;
    int n_total = 0;
    int m_ptr   = 0;

    // flex_spi stand-in controls
    int wlen      = 2;
    bit ones      = 1'b0;
    bit hold_done = 1'b0;
    bit spurious  = 1'b0;

    always #5 clk = ~clk;

    spi_arbiter #(.N_REQ(N), .ID_W(2), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_lock(req_lock), .req_tx(req_tx),
        .req_cfg(req_cfg), .gnt(gnt), .ack(ack), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_id(rx_id), .rx_err(rx_err), .spi_en(spi_en),
        .spi_we(spi_we), .spi_oe(spi_oe), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
        .spi_xfer_len(spi_xfer_len), .spi_tx(spi_tx), .spi_tx_oe(spi_tx_oe),
        .spi_rx(spi_rx), .spi_busy(spi_busy), .spi_done(spi_done)
    );

    // Behavioural flex_spi: done after wlen cycles of WAIT, rx = all ones or ~tx
    initial begin
        int cnt;
        logic [7:0] word;
        cnt = 0; word = '0;
        spi_done = 1'b0; spi_rx = '0; spi_busy = 1'b0;
        forever begin
            @(negedge clk);
            spi_done = spurious;
            if (!spi_en) begin
                cnt = 0;
            end else if (spi_we) begin
                word = ones ? 8'hFF : ~spi_tx;
                cnt  = hold_done ? 0 : wlen;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    spi_done = 1'b1;
                    spi_rx   = word;
                end
            end
            spi_busy = (cnt > 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [5:0] fixcfg(input logic [5:0] c);
        logic [3:0] l;
        l = c[3:0];
        if (l == 4'd0 || l > 4'd8) l = 4'd8;
        return {c[5:4], l};
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic wait_we(output int n, output bit ok);
        ok = 1'b0; n = 0;
        while (!ok && n < 64) begin
            @(negedge clk);
            n++;
            if (spi_we) ok = 1'b1;
        end
    endtask

    // One complete transfer: checks at LOAD and at ACK; returns at the ACK negedge
    task automatic xfer(input int id, input logic [7:0] tx, input logic [5:0] cfg,
                        input logic [7:0] rx, input int lat, input int gap,
                        input bit err, input bit scr);
        int n, oe_n, enl_n;
        bit ok;
        logic [3:0] oh;
        oh = 4'b0001 << id;
        wait_we(n, ok);
        if (!ok) begin
            n_total++;
            $display("FAIL load_wait: no spi_we within 64 cycles, want id %0d", id);
            return;
        end
        check("gap", n, gap);
        check("gnt_load", gnt, oh);
        check("load_bus", {spi_en, spi_tx_oe, spi_oe, spi_tx}, {3'b110, tx});
        check("cfg_load", {spi_cpol, spi_cpha, spi_xfer_len}, cfg);
        if (scr) begin
            req_tx[id*DW +: DW] = 8'($urandom);
            req_cfg[id*6 +: 6]  = 6'($urandom);
        end
        n = 0; oe_n = 0; enl_n = 0; ok = 1'b0;
        while (!ok && n < TO + 64) begin
            @(negedge clk);
            n++;
            if (spi_oe) oe_n++;
            if (!spi_en) enl_n++;
            if (|ack) ok = 1'b1;
        end
        if (!ok) begin
            n_total++;
            $display("FAIL ack_wait: no ack within %0d cycles, want id %0d", TO + 64, id);
            return;
        end
        check("latency", n, lat);
        check("ack", ack, oh);
        check("rx", {rx_valid, rx_err, rx_id, rx_data}, {1'b1, err, 2'(id), rx});
        check("gnt_ack", gnt, oh);
        check("cfg_ack", {spi_cpol, spi_cpha, spi_xfer_len}, cfg);
        check("oe_pulses", oe_n, err ? 0 : 1);
        check("en_low", enl_n, err ? 1 : 0);
        m_ptr = (id + 1) % N;
    endtask

    typedef struct {
        int         id;
        logic [7:0] tx;
        logic [5:0] cfg;
        bit         ones;
        int         wlen;
        logic [5:0] exp_cfg;
        logic [7:0] exp_rx;
    } vec_t;

    initial begin
        vec_t vecs[5];
        logic [N-1:0] rq, lk;
        int n, prev, run, g, k;
        bit ok, seen;

        vecs[0] = '{1, 8'hAA, 6'h18, 1'b1, 3, 6'h18, 8'hFF};
        vecs[1] = '{0, 8'h3C, 6'h24, 1'b0, 1, 6'h24, 8'hC3};
        vecs[2] = '{2, 8'h5A, 6'h10, 1'b0, 2, 6'h18, 8'hA5};
        vecs[3] = '{3, 8'h81, 6'h3C, 1'b1, 4, 6'h38, 8'hFF};
        vecs[4] = '{0, 8'h00, 6'h01, 1'b0, 6, 6'h01, 8'hFF};

        // Reset dominates even with every request and lock asserted
        rst = 1'b1; req = '1; req_lock = '1; req_tx = '1; req_cfg = '1;
        repeat (3) @(negedge clk);
        check("rst_out_a", {gnt, ack, rx_data, rx_valid, rx_id, rx_err}, 0);
        check("rst_out_b", {spi_en, spi_we, spi_oe, spi_cpol, spi_cpha, spi_xfer_len,
                            spi_tx, spi_tx_oe}, 0);
        rst = 1'b0; req = '0; req_lock = '0; m_ptr = 0;

        // No requests plus a stray done: nothing may start
        repeat (2) @(negedge clk);
        spurious = 1'b1;
        @(negedge clk);
        spurious = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (spi_en || |gnt || |ack || rx_valid || spi_cpol || |spi_xfer_len) seen = 1'b1;
        end
        check("idle_quiet", seen, 0);

        // Contention: all four held, order 0,1,2,3,0
        for (int i = 0; i < N; i++) begin
            req_tx[i*DW +: DW] = 8'h10 + 8'(i);
            req_cfg[i*6 +: 6]  = {2'b00, 4'(i + 1)};
        end
        wlen = 2; ones = 1'b0; req = 4'b1111;
        begin
            int order[5] = '{0, 1, 2, 3, 0};
            for (int t = 0; t < 5; t++) begin
                xfer(order[t], 8'h10 + 8'(order[t]), {2'b00, 4'(order[t] + 1)},
                     ~(8'h10 + 8'(order[t])), 4, (t == 0) ? 1 : 2, 1'b0, 1'b0);
            end
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Directed vectors, one requester at a time
        for (int v = 0; v < 5; v++) begin
            req_tx[vecs[v].id*DW +: DW] = vecs[v].tx;
            req_cfg[vecs[v].id*6 +: 6]  = vecs[v].cfg;
            ones = vecs[v].ones; wlen = vecs[v].wlen;
            req  = 4'b0001 << vecs[v].id;
            xfer(vecs[v].id, vecs[v].tx, vecs[v].exp_cfg, vecs[v].exp_rx,
                 vecs[v].wlen + 2, 1, 1'b0, 1'b0);
            req = '0;
            repeat (2) @(negedge clk);
        end

        // Reset during WAIT: port released next cycle, no ack, pointer back to 0
        ones = 1'b0; wlen = 50;
        req_tx[2*DW +: DW] = 8'h77; req_cfg[2*6 +: 6] = 6'h08;
        req = 4'b0100;
        wait_we(n, ok);
        check("rst_load", {ok, 8'(n)}, {1'b1, 8'd1});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", {spi_en, gnt, ack, rx_valid}, 0);
        rst = 1'b0; req = '0; m_ptr = 0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (|ack || rx_valid || spi_en) seen = 1'b1;
        end
        check("rst_no_ack", seen, 0);

        // Lock fairness: four chained req0 transfers, then req1
        wlen = 1;
        req_tx[0 +: DW] = 8'hC0; req_cfg[0 +: 6] = 6'h08;
        req_tx[DW +: DW] = 8'h0F; req_cfg[6 +: 6] = 6'h32;
        req_lock = 4'b0001; req = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            xfer(0, 8'hC0, 6'h08, 8'h3F, 3, 1, 1'b0, 1'b0);
        end
        xfer(1, 8'h0F, 6'h32, 8'hF0, 3, 2, 1'b0, 1'b0);
        req = '0; req_lock = '0;
        repeat (2) @(negedge clk);

`ifdef SPI_ARBITER_TIMEOUT_EN
        // Watchdog: done never comes
        hold_done = 1'b1;
        req_tx[0 +: DW] = 8'h99; req_cfg[0 +: 6] = 6'h24;
        req = 4'b0001;
        xfer(0, 8'h99, 6'h24, 8'h00, TO + 2, 1, 1'b1, 1'b0);
        req = '0; hold_done = 1'b0;
        repeat (2) @(negedge clk);
`endif

        // Randomized batches against the grant-order model
        for (int b = 0; b < 12; b++) begin
            rq = 4'($urandom_range(1, 15));
            lk = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                req_tx[i*DW +: DW] = 8'($urandom);
                req_cfg[i*6 +: 6]  = 6'($urandom);
            end
            ones = 1'($urandom_range(0, 1));
            k = $urandom_range(3, 9);
            prev = -1; run = 0;
            req = rq; req_lock = lk;
            for (int t = 0; t < k; t++) begin
                int gap;
                logic [7:0] etx;
                if (prev >= 0 && lk[prev] && rq[prev] && run < 4) begin
                    g = prev; run++; gap = 1;
                end else begin
                    g = pick(rq, m_ptr); run = 1; gap = (t == 0) ? 1 : 2;
                end
                wlen = $urandom_range(1, 6);
                etx = req_tx[g*DW +: DW];
                xfer(g, etx, fixcfg(req_cfg[g*6 +: 6]), ones ? 8'hFF : ~etx,
                     wlen + 2, gap, 1'b0, 1'b1);
                prev = g;
            end
            req = '0; req_lock = '0;
            repeat (2) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
